// File: rtl/s7_display_rx.sv
// Receiver for a multiplexed 7-segment bus: rebuilds per-digit 4-bit codes and publishes whole frames.
// Optional saturating error counter with clear input: define S7_DISPLAY_RX_ERR_CNT_EN.
module s7_display_rx #(
   parameter int DISPLAYS_NUM     = 4,
   parameter int STABLE_CLK_COUNT = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [6:0]                i_segments,
   input  logic [DISPLAYS_NUM-1:0]   i_segments_sel,
`ifdef S7_DISPLAY_RX_ERR_CNT_EN
   input  logic                      i_err_clr,
   output logic [7:0]                o_err_count,
`endif
   output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
   output logic                      o_valid,
   output logic                      o_err
);

   localparam int         IW     = DISPLAYS_NUM + 7;
   localparam logic [7:0] STABLE = 8'(STABLE_CLK_COUNT);

   logic [IW-1:0]             in_now;
   logic [IW-1:0]             prev_reg;
   logic [7:0]                cnt_reg;
   logic [7:0]                cnt_next;
   logic [DISPLAYS_NUM*4-1:0] shadow_reg;
   logic [DISPLAYS_NUM*4-1:0] shadow_next;
   logic [DISPLAYS_NUM-1:0]   mask_reg;
   logic [DISPLAYS_NUM-1:0]   mask_next;
   logic [DISPLAYS_NUM-1:0]   hit;
   logic                      match;
   logic                      capture;
   logic                      sel_any;
   logic                      sel_multi;
   logic                      one_hot;
   logic [4:0]                seg_dec;
   logic                      seg_ok;
   logic [3:0]                code;
   logic                      store;
   logic                      err_next;
   logic                      frame_done;

   // Returns {valid, code}; anything outside the 16 glyphs is rejected.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h10;
         7'h06:   decode = 5'h11;
         7'h5B:   decode = 5'h12;
         7'h4F:   decode = 5'h13;
         7'h66:   decode = 5'h14;
         7'h6D:   decode = 5'h15;
         7'h7D:   decode = 5'h16;
         7'h07:   decode = 5'h17;
         7'h7F:   decode = 5'h18;
         7'h6F:   decode = 5'h19;
         7'h77:   decode = 5'h1A;
         7'h7C:   decode = 5'h1B;
         7'h39:   decode = 5'h1C;
         7'h5E:   decode = 5'h1D;
         7'h79:   decode = 5'h1E;
         7'h71:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   assign in_now = {i_segments_sel, i_segments};
   assign match  = (in_now == prev_reg);

   always_comb begin
      cnt_next = cnt_reg;
      if (!match)
         cnt_next = 8'd0;
      else if (cnt_reg != STABLE)
         cnt_next = cnt_reg + 8'd1;
   end

   // The counter saturates, so reaching STABLE happens only once per dwell.
   assign capture    = match && (cnt_reg == STABLE - 8'd1);
   assign sel_any    = |i_segments_sel;
   assign sel_multi  = (i_segments_sel & (i_segments_sel - 1'b1)) != '0;
   assign one_hot    = sel_any && !sel_multi;
   assign seg_dec    = decode(i_segments);
   assign seg_ok     = seg_dec[4];
   assign code       = seg_dec[3:0];
   assign store      = capture && one_hot && seg_ok;
   assign err_next   = capture && (sel_multi || (one_hot && !seg_ok));
   assign frame_done = &mask_reg;

   generate
      for (genvar gi = 0; gi < DISPLAYS_NUM; gi++) begin : g_digit
         assign hit[gi]               = store && i_segments_sel[gi];
         assign mask_next[gi]         = hit[gi] || (mask_reg[gi] && !frame_done);
         assign shadow_next[gi*4 +: 4] = hit[gi] ? code : shadow_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_reg   <= '0;
         cnt_reg    <= 8'd0;
         shadow_reg <= '0;
         mask_reg   <= '0;
         o_bcd_data <= '0;
         o_valid    <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         prev_reg   <= in_now;
         cnt_reg    <= cnt_next;
         shadow_reg <= shadow_next;
         mask_reg   <= mask_next;
         o_valid    <= frame_done;
         o_err      <= err_next;
         // shadow_reg already holds the digit captured in the previous cycle
         if (frame_done)
            o_bcd_data <= shadow_reg;
      end
   end

`ifdef S7_DISPLAY_RX_ERR_CNT_EN
   logic [7:0] err_count_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         err_count_reg <= 8'd0;
      else if (i_err_clr)
         err_count_reg <= 8'd0;
      else if (err_next && (err_count_reg != 8'hFF))
         err_count_reg <= err_count_reg + 8'd1;
   end

   assign o_err_count = err_count_reg;
`endif

endmodule
